// File: rtl/bnn_frame_scheduler_if.sv
// bnn_frame_scheduler_if: per-source pixel and result handshakes between the sources and the scheduler.
interface bnn_frame_scheduler_if #(parameter int NREQ = 2);
  logic [NREQ-1:0] src_valid;
  logic [NREQ-1:0] src_pix;
  logic [NREQ-1:0] src_ready;
  logic [NREQ-1:0] res_valid;
  logic [NREQ-1:0] res_ready;
  logic [3:0]      res_class;
  modport master (output src_valid, src_pix, res_ready, input src_ready, res_valid, res_class);
  modport slave  (input src_valid, src_pix, res_ready, output src_ready, res_valid, res_class);
endinterface

// File: rtl/bnn_frame_scheduler.sv
// bnn_frame_scheduler: round-robin whole-frame sharing of one BNN core between NREQ sources.
// Define BNN_PERF_CNT_EN to enable the perf_cycles frame-latency counter.
module bnn_frame_scheduler #(
  parameter int NREQ      = 2,
  parameter int GW        = 1,
  parameter int PIXEL_NUM = 784,
  parameter int CW        = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  bnn_frame_scheduler_if.slave sif,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  input  logic                 core_rcv_req,
  output logic                 core_rcv_ack,
  output logic                 core_inputs,
  output logic                 core_snd_req,
  input  logic                 core_snd_ack,
  input  logic [3:0]           core_outputs,
  output logic [31:0]          perf_cycles
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_RDY, SEND, RESULT, RETURN} state_e;
  state_e               state_q;
  logic [GW-1:0]        rr_q, gnt_q, gsel, idx;
  logic [CW-1:0]        cnt_q;
  logic [PIXEL_NUM-1:0] buf_q;
  logic [NREQ-1:0]      src_ready_q, res_valid_q;
  logic [3:0]           res_class_q;
  logic                 rcv_ack_q, pix_q, snd_req_q, busy_q, acc;
  assign acc              = (state_q == LOAD) & sif.src_valid[gnt_q];
  assign sif.src_ready    = src_ready_q;
  assign sif.res_valid    = res_valid_q;
  assign sif.res_class    = res_class_q;
  assign grant_id         = gnt_q;
  assign busy             = busy_q;
  assign core_rcv_ack     = rcv_ack_q;
  assign core_inputs      = pix_q;
  assign core_snd_req     = snd_req_q;
  // Descending scan so the requester closest above rr_q wins.
  always_comb begin
    gsel = rr_q;
    idx  = rr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = GW'((int'(rr_q) + i) % NREQ);
      if (sif.src_valid[idx]) gsel = idx;
    end
  end
  always_ff @(posedge clk)
    if (acc) buf_q[cnt_q] <= sif.src_pix[gnt_q];
  always_ff @(posedge clk)
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      src_ready_q <= '0;
      res_valid_q <= '0;
      res_class_q <= '0;
      rcv_ack_q   <= 1'b0;
      pix_q       <= 1'b0;
      snd_req_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else
      case (state_q)
        IDLE: if (|sif.src_valid) begin
          gnt_q       <= gsel;
          src_ready_q <= NREQ'(1) << gsel;
          busy_q      <= 1'b1;
          state_q     <= LOAD;
        end
        LOAD: if (acc) begin
          if (cnt_q == CW'(PIXEL_NUM - 1)) begin
            cnt_q       <= '0;
            src_ready_q <= '0;
            state_q     <= WAIT_RDY;
          end else cnt_q <= cnt_q + CW'(1);
        end
        WAIT_RDY: if (core_rcv_req) begin
          rcv_ack_q <= 1'b1;
          pix_q     <= buf_q[0];
          cnt_q     <= CW'(1);
          state_q   <= SEND;
        end
        SEND: if (cnt_q == CW'(PIXEL_NUM)) begin
          rcv_ack_q <= 1'b0;
          pix_q     <= 1'b0;
          cnt_q     <= '0;
          snd_req_q <= 1'b1;
          state_q   <= RESULT;
        end else begin
          pix_q <= buf_q[cnt_q];
          cnt_q <= cnt_q + CW'(1);
        end
        RESULT: if (core_snd_ack) begin
          res_class_q <= core_outputs;
          snd_req_q   <= 1'b0;
          res_valid_q <= NREQ'(1) << gnt_q;
          state_q     <= RETURN;
        end
        RETURN: if (sif.res_ready[gnt_q]) begin
          res_valid_q <= '0;
          rr_q        <= (gnt_q == GW'(NREQ - 1)) ? '0 : gnt_q + GW'(1);
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
`ifdef BNN_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_q, perf_inc;
  // perf_inc counts the current cycle too, so the snapshot equals all busy cycles so far.
  assign perf_inc    = &perf_cnt_q ? perf_cnt_q : perf_cnt_q + 32'd1;
  assign perf_cycles = perf_q;
  always_ff @(posedge clk)
    if (rst) begin
      perf_cnt_q <= '0;
      perf_q     <= '0;
    end else begin
      perf_cnt_q <= (state_q == IDLE && |sif.src_valid) ? '0 : busy_q ? perf_inc : perf_cnt_q;
      if (state_q == RESULT && core_snd_ack) perf_q <= perf_inc;
    end
`else
  assign perf_cycles = '0;
`endif
endmodule

// File: tb/tb_bnn_frame_scheduler.sv
// tb_bnn_frame_scheduler: scoreboard bench; frames are queued at issue and checked by a monitor.
module tb_bnn_frame_scheduler;
  localparam int PN = 784;
  typedef struct {
    int          src;
    logic [PN-1:0] frame;
    logic [3:0]  cls;
    logic [31:0] perf;
    bit          pchk;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic core_rcv_req, core_rcv_ack, core_inputs, core_snd_req, core_snd_ack;
  logic [3:0] core_outputs;
  logic [0:0] grant_id;
  logic busy;
  logic [31:0] perf_cycles;
  logic [1:0] sv, sp, active, gap, phase;
  logic [9:0] idx [2];
  logic [PN-1:0] frame [2];
  logic [9:0] rx_n;
  logic [PN-1:0] rx;
  int snd_delay = 5;
  int checks = 0, errors = 0;
  exp_t exp_q[$];
  bnn_frame_scheduler_if #(.NREQ(2)) sif ();
  assign sif.src_valid = sv;
  assign sif.src_pix   = sp;
  always #5 clk = ~clk;
  bnn_frame_scheduler #(.NREQ(2), .GW(1), .PIXEL_NUM(PN), .CW(10)) dut (
    .clk(clk), .rst(rst), .sif(sif), .grant_id(grant_id), .busy(busy),
    .core_rcv_req(core_rcv_req), .core_rcv_ack(core_rcv_ack), .core_inputs(core_inputs),
    .core_snd_req(core_snd_req), .core_snd_ack(core_snd_ack), .core_outputs(core_outputs),
    .perf_cycles(perf_cycles)
  );
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask
  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s got unexpected output want none", nm);
  endtask
  function automatic logic [31:0] perf_exp();
`ifdef BNN_PERF_CNT_EN
    return 32'(PN + 1 + PN + snd_delay + 1);
`else
    return 32'd0;
`endif
  endfunction
  task automatic start(input int s, input logic [PN-1:0] f, input bit g, input bit pc);
    exp_t e;
    frame[s] = f;
    idx[s] = '0;
    if (s == 0) begin active[0] = 1'b1; gap[0] = g; phase[0] = 1'b1; end
    else begin active[1] = 1'b1; gap[1] = g; phase[1] = 1'b1; end
    e.src = s; e.frame = f; e.cls = 4'($countones(f)); e.perf = perf_exp(); e.pchk = pc;
    exp_q.push_back(e);
  endtask
  task automatic step();
    logic [1:0] acc;
    sv = active & (~gap | phase);
    sp = active & {frame[1][idx[1]], frame[0][idx[0]]};
    @(negedge clk);
    acc = sv & sif.src_ready;
    @(posedge clk);
    #1;
    if (acc[0]) idx[0] = idx[0] + 10'd1;
    if (acc[1]) idx[1] = idx[1] + 10'd1;
    if (idx[0] == 10'(PN)) active[0] = 1'b0;
    if (idx[1] == 10'(PN)) active[1] = 1'b0;
    phase = ~phase;
  endtask
  task automatic run_done(input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || active != 0) && n < maxc) begin
      step();
      n++;
    end
    chk("run_done", 64'(n < maxc), 64'd1);
  endtask
  task automatic chk_zero(input string nm);
    chk(nm, 64'({sif.src_ready, sif.res_valid, sif.res_class, grant_id, busy,
                 core_rcv_ack, core_inputs, core_snd_req}), 64'd0);
    chk({nm, "_perf"}, 64'(perf_cycles), 64'd0);
  endtask
  // Core model: class is the popcount of the received frame, acked snd_delay cycles after the request.
  initial begin
    int ones = 0, wcnt = 0;
    core_snd_ack = 1'b0;
    core_outputs = 4'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        core_snd_ack = 1'b0; ones = 0; wcnt = 0;
      end else begin
        if (core_rcv_ack && core_inputs) ones++;
        if (core_snd_req && !core_snd_ack) begin
          if (wcnt >= snd_delay) begin
            core_snd_ack = 1'b1; core_outputs = 4'(ones); ones = 0;
          end else wcnt++;
        end else if (!core_snd_req) begin
          core_snd_ack = 1'b0; wcnt = 0;
        end
      end
    end
  end
  initial begin
    logic ack_p = 1'b0, busy_p = 1'b0;
    rx_n = '0;
    rx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rx_n = '0; rx = '0; ack_p = 1'b0; busy_p = 1'b0;
      end else begin
        if (busy && !busy_p) begin
          if (exp_q.size() == 0) fail("grant_unexpected");
          else chk("grant", 64'(grant_id), 64'(exp_q[0].src));
        end
        if (sif.src_ready != 0 && exp_q.size() != 0)
          chk("src_ready", 64'(sif.src_ready), 64'(2'b01 << exp_q[0].src));
        if (core_rcv_ack) begin
          if (rx_n < 10'(PN)) rx[rx_n] = core_inputs;
          rx_n = rx_n + 10'd1;
        end else if (ack_p) begin
          if (exp_q.size() == 0) fail("frame_unexpected");
          else begin
            chk("frame_len", 64'(rx_n), 64'(PN));
            chk("frame_bits_wrong", 64'($countones(rx ^ exp_q[0].frame)), 64'd0);
          end
          rx_n = '0; rx = '0;
        end
        if (sif.res_valid != 0) begin
          if (exp_q.size() == 0) fail("res_unexpected");
          else begin
            chk("res_valid", 64'(sif.res_valid), 64'(2'b01 << exp_q[0].src));
            chk("res_class", 64'(sif.res_class), 64'(exp_q[0].cls));
            if (exp_q[0].pchk) chk("perf_cycles", 64'(perf_cycles), 64'(exp_q[0].perf));
            if ((sif.res_valid & sif.res_ready) != 0) void'(exp_q.pop_front());
          end
        end
        ack_p = core_rcv_ack;
        busy_p = busy;
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [PN-1:0] f;
    sv = '0; sp = '0; active = '0; gap = '0; phase = '0;
    idx[0] = '0; idx[1] = '0; frame[0] = '0; frame[1] = '0;
    core_rcv_req = 1'b1;
    sif.res_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;
    f = PN'(8'h7F) << 5;
    start(0, f, 1'b0, 1'b1);
    run_done(4000);
    rst = 1'b1; step(); rst = 1'b0;
    snd_delay = 0;
    f = PN'(12'hFFF);
    start(0, f, 1'b0, 1'b1);
    f = '1;
    start(1, f, 1'b0, 1'b1);
    run_done(8000);
    f = {392{2'b10}};
    start(0, f, 1'b0, 1'b1);
    f = PN'(64'hDEAD_BEEF_0123_4567) << 300;
    start(1, f, 1'b0, 1'b1);
    run_done(8000);
    snd_delay = 2;
    core_rcv_req = 1'b0;
    f = {98{8'hA7}};
    start(1, f, 1'b1, 1'b0);
    for (int n = 0; n < 4000 && active[1]; n++) step();
    repeat (20) begin
      step();
      chk("wait_hold", 64'({busy, core_rcv_ack}), 64'd2);
    end
    core_rcv_req = 1'b1;
    run_done(4000);
    snd_delay = 3;
    sif.res_ready = 2'b00;
    f = PN'(16'hBEEF) << 700;
    start(0, f, 1'b0, 1'b1);
    f = {49{16'h1357}};
    start(1, f, 1'b0, 1'b1);
    for (int n = 0; n < 4000 && !sif.res_valid[0]; n++) step();
    repeat (10) begin
      step();
      chk("bp_hold", 64'({busy, grant_id, sif.res_valid}), 64'(4'b1001));
    end
    sif.res_ready = 2'b11;
    run_done(8000);
    f = {196{4'b1100}};
    start(1, f, 1'b0, 1'b1);
    for (int n = 0; n < 4000 && rx_n < 10'd300; n++) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk_zero("reset_send");
    chk("reset_abandon", 64'(exp_q.size()), 64'd0);
    f = PN'(32'h0F0F_00FF) << 17;
    start(0, f, 1'b0, 1'b1);
    f = {196{4'b1100}};
    start(1, f, 1'b0, 1'b1);
    run_done(8000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bnn_frame_scheduler.md
Name: bnn_frame_scheduler

Overview:
- Shares one BinarizedNeuralNetwork core between NREQ image sources at whole-frame granularity, using round-robin arbitration.
- Buffers one 28x28 binary frame from the granted source, then streams it into the core's receive port (core rcv_req / master rcv_ack).
- Collects the 4-bit class from the core's send port (master snd_req / core snd_ack) and returns it to the source that owns the frame.
- Sits between the pixel sources and the core; does not drive the core's own reset.

Parameters:
- NREQ, 2: number of requesting sources.
- GW, 1: grant index width; must be at least clog2(NREQ).
- PIXEL_NUM, 784: pixels per frame.
- CW, 10: pixel counter width; must be at least clog2(PIXEL_NUM+1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- src_valid  in  NREQ  per-source pixel valid; the first valid of a frame also acts as the request.
- src_pix  in  NREQ  per-source pixel bit.
- src_ready  out  NREQ  per-source pixel accept.
- res_valid  out  NREQ  per-source result valid.
- res_class  out  4  class of the returned frame.
- res_ready  in  NREQ  per-source result accept.
- grant_id  out  GW  index of the source currently owning the core.
- busy  out  1  high in every state except IDLE.
- core_rcv_req  in  1  core ready to take a frame.
- core_rcv_ack  out  1  pixel strobe to the core.
- core_inputs  out  1  pixel bit to the core.
- core_snd_req  out  1  result request to the core.
- core_snd_ack  in  1  core result valid.
- core_outputs  in  4  core class result.
- perf_cycles  out  32  frame latency (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr=0; pixel counter 0; frame buffer contents don't-care.
- Reset mid-operation clears everything on the next edge. A partially sent frame is abandoned; core_rcv_ack and core_snd_req drop immediately after that edge.
- IDLE:
  - If any src_valid is high, grant the first asserted index searching upward from rr_ptr, with wrap.
  - Latch grant_id, then go to LOAD.
  - src_ready stays 0 in IDLE, so no pixel is consumed on the grant cycle.
- LOAD:
  - src_ready[grant_id]=1; all other src_ready bits are 0.
  - Each cycle with src_valid[g]&src_ready[g] stores src_pix[g] at buffer[cnt] and increments cnt.
  - Gaps in src_valid are allowed.
  - On the accept with cnt==PIXEL_NUM-1: clear cnt, go to WAIT_RDY.
  - Valids on non-granted sources are ignored; they stay pending.
- WAIT_RDY: wait until core_rcv_req is sampled 1, then go to SEND on the next edge. This gives one idle cycle after req before the first pixel.
- SEND:
  - core_rcv_ack=1 and core_inputs=buffer[cnt] for exactly PIXEL_NUM consecutive cycles, pixel 0 first, no gaps.
  - core_rcv_ack=0 on the cycle after the last pixel.
  - Go to RESULT.
- RESULT:
  - core_snd_req=1 until core_snd_ack is sampled 1.
  - On that edge, capture core_outputs into res_class, drop core_snd_req, go to RETURN.
  - Values above 9 pass through unmodified.
- RETURN:
  - res_valid[grant_id]=1 with res_class stable until res_ready[grant_id] is sampled 1.
  - Then res_valid drops, rr_ptr=grant_id+1 (wrapping at NREQ), state goes to IDLE.
- Latency from the last LOAD accept to the first core_rcv_ack, with core_rcv_req already high: 2 cycles.
- Simultaneous events:
  - res_ready held high at RETURN entry completes RETURN in 1 cycle.
  - core_snd_ack high at RESULT entry is captured on the first RESULT edge.
- Throughput: one frame in flight; a new grant only happens after RETURN completes.

Optional Feature:
- Macro BNN_PERF_CNT_EN.
- Defined:
  - A 32-bit counter clears on the grant edge and increments every cycle while busy.
  - perf_cycles is loaded with the counter value on the edge entering RETURN and holds until the next entry to RETURN.
  - Counter saturates at 0xFFFFFFFF.
- Undefined: perf_cycles is tied to 0 and no counter logic is synthesized.

Test Plan:
- Single source: src0 streams 784 pixels with no gaps, core_rcv_req=1, core_snd_ack after 5 cycles with outputs=7.
  - Exactly 784 core_rcv_ack cycles, bit-exact pixel order, res_valid[0] with res_class=7.
- Contention: src0 and src1 both valid in IDLE after reset.
  - Grant 0 first, then 1.
  - Next round with both valid: grant 0 again, because rr_ptr wraps after serving 1.
- Gapped load: src_valid toggles every other cycle.
  - 784 pixels still captured.
  - SEND burst still has no gaps; WAIT_RDY holds while core_rcv_req=0 for 20 cycles.
- Backpressure: res_ready low for 10 cycles.
  - res_valid and res_class stable throughout; no new grant until the accept.
- Reset in SEND at pixel 300.
  - All outputs 0 the next cycle.
  - Next grant goes to source 0 and loads a fresh frame.
- With BNN_PERF_CNT_EN: known stall pattern, e.g. 784 load + 1 + 784 + 3 wait + 5 ack cycles.
  - perf_cycles equals the exact count of busy cycles.
  - Without the macro, perf_cycles reads 0.
